// File: rtl/zbb_pkg.sv
`default_nettype none
// ============================================================================
// zbb_pkg : shared op encodings, FSM states and widths for the Zbb count unit
// Rev 1.0
// ============================================================================
package zbb_pkg;

    localparam int XLEN  = 32;
    localparam int IDX_W = 5;
    localparam int TAG_W = 5;

    typedef enum logic [1:0] {
        OP_CTZ  = 2'b00,
        OP_CLZ  = 2'b01,
        OP_CPOP = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/zbb_count_unit_trailing2.sv
`default_nettype none
// ============================================================================
// trailing2 : index of the lowest set bit of a 32-bit word (0 for a zero word)
// Rev 1.0
// ============================================================================
module trailing2
    import zbb_pkg::*;
(
    input  logic [XLEN-1:0]  i_data,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the top so the last hit, the lowest set bit, wins.
    always_comb begin
        o_idx = '0;
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (i_data[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/zbb_count_unit.sv
`default_nettype none
// ============================================================================
// zbb_count_unit : multi-cycle CTZ / CLZ / CPOP execute unit with handshakes
// Rev 1.0
// ============================================================================
module zbb_count_unit
    import zbb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [TAG_W-1:0]  out_tag
);

    state_e             r_state;
    state_e             w_next;
    op_e                r_op;
    logic [XLEN-1:0]    r_work;
    logic [CNT_W-1:0]   r_cnt;
    logic [TAG_W-1:0]   r_tag;
    logic [XLEN-1:0]    r_result;
    logic [XLEN-1:0]    w_rev;
    logic [IDX_W-1:0]   w_idx;
    logic               w_zero;
    logic               w_accept;

    // CLZ becomes CTZ on the bit-reversed operand.
    for (genvar i = 0; i < XLEN; i++) begin : g_rev
        assign w_rev[i] = in_rs1[XLEN-1-i];
    end

    trailing2 u_trailing2 (
        .i_data (r_work),
        .o_idx  (w_idx)
    );

    // trailing2 reports 0 for both bit 0 and an empty word, so zero is tested here.
    assign w_zero   = (r_work == '0);
    assign w_accept = (r_state == IDLE) && in_valid && !flush;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = SCAN;
            end
            SCAN: begin
                if (flush)                             w_next = IDLE;
                else if (!(r_op == OP_CPOP && !w_zero)) w_next = DONE;
            end
            DONE: begin
                if (flush || out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= OP_CTZ;
            r_tag    <= '0;
            r_work   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op   <= op_e'(in_op);
            r_tag  <= in_tag;
            r_work <= (op_e'(in_op) == OP_CLZ) ? w_rev : in_rs1;
            r_cnt  <= '0;
        end else if (r_state == SCAN && !flush) begin
            case (r_op)
                OP_CTZ, OP_CLZ: begin
                    r_result <= w_zero ? XLEN'(XLEN) : XLEN'(w_idx);
                end
                OP_CPOP: begin
                    // One set bit retired per cycle; the count cannot pass XLEN.
                    if (w_zero) begin
                        r_result <= XLEN'(r_cnt);
                    end else begin
                        r_cnt         <= r_cnt + CNT_W'(1);
                        r_work[w_idx] <= 1'b0;
                    end
                end
                default: r_result <= '0;
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign out_result = r_result;
    assign out_tag    = r_tag;

endmodule
`default_nettype wire

// File: doc/zbb_count_unit.md
Name: zbb_count_unit

Overview:
- Multi-cycle execute-stage unit for the Zbb count instructions CTZ, CLZ and CPOP on 32-bit operands.
- Sits downstream of the shared combinational trailing-zero counter (trailing2) and consumes its 5-bit index.
- Sits between the issue stage and the writeback arbiter, with a valid/ready handshake on both sides.
- CPOP is computed iteratively: each cycle clears the lowest set bit at the index trailing2 reports.

Parameters:
- XLEN, 32, operand width; only 32 is legal because trailing2 is fixed at 32 bits.
- CNT_W, 6, width of the internal count register; must hold 0..32.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  pipeline flush; aborts any operation in progress.
- in_valid  input  1  issue side offers an operation.
- in_ready  output  1  unit can accept; high only in IDLE.
- in_op  input  2  operation: 00 CTZ, 01 CLZ, 10 CPOP, 11 reserved.
- in_rs1  input  32  source operand.
- in_tag  input  5  destination register index; returned unchanged with the result.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  writeback accepts the result.
- out_result  output  32  zero-extended count.
- out_tag  output  5  tag captured at accept.

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to IDLE.
  - in_ready=1, out_valid=0, out_result=0, out_tag=0.
  - Internal work register=0 and count register=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - Accept when in_valid && in_ready at edge N.
  - Latch op and tag.
  - Latch the work register: in_rs1 for CTZ and CPOP; bit-reversed in_rs1 for CLZ.
  - Clear the count register; go to SCAN.
- SCAN, CTZ/CLZ (one cycle):
  - Result = 32 if work==0, else the trailing2 index zero-extended.
  - The zero test is local because trailing2 returns 0 for a zero input.
  - Go to DONE, so out_valid rises at edge N+2.
- SCAN, CPOP:
  - If work==0: result = count; go to DONE.
  - Else: count += 1 and clear work bit [idx] (idx from trailing2); stay in SCAN.
  - An operand with k set bits spends k+1 cycles in SCAN, so out_valid rises at edge N+2+k.
  - Boundaries: operand 0 takes 2 cycles; 0xFFFFFFFF takes 34 cycles and gives result 32.
- SCAN, reserved op 11: result=0, one cycle, go to DONE. No trap; decode has already filtered illegal ops.
- DONE:
  - out_valid=1.
  - out_result and out_tag are held stable until out_valid && out_ready.
  - On that handshake, go to IDLE and drop out_valid the next cycle.
  - No bypass: a new accept is possible at the earliest one cycle after the handshake, so peak throughput is one op per 3 cycles.
- in_ready is a pure decode of state==IDLE and has no combinational path from in_valid.
- out_valid depends only on state.
- flush:
  - In SCAN or DONE, the next state is IDLE and out_valid goes low next cycle.
  - The result is discarded; work and count registers are not cleared (don't-care in IDLE).
  - flush in IDLE blocks the accept in that cycle: an in_valid in the same cycle is not accepted, and in_ready stays high.
  - flush and out_ready together in DONE: flush wins and the handshake is not counted. Writeback must ignore out_valid during flush.
- Reset asserted mid-SCAN or in DONE returns the unit to the reset values immediately, without waiting for a clock edge.
- Arithmetic: count saturates naturally at 32 because at most 32 bits exist. CNT_W=6 covers this with no wrap.

Decomposition:
- Shared package zbb_pkg:
  - Op encodings: OP_CTZ=2'b00, OP_CLZ=2'b01, OP_CPOP=2'b10, OP_RSVD=2'b11.
  - State enum: IDLE, SCAN, DONE.
  - Constant XLEN=32.
- One sub-module: instantiate trailing2 on the work register; its output feeds both the CTZ/CLZ result and the CPOP bit-clear index.
- The bit-reverse is a generate loop inside this block, not a separate module.

Test Plan:
- CTZ 0x00000008, tag 5, out_ready held 1 -> out_result=3, out_tag=5, out_valid exactly 2 cycles after accept.
- CLZ 0x00010000 -> 15. CLZ 0x00000000 -> 32. CTZ 0x00000000 -> 32. CTZ 0x80000000 -> 31.
- CPOP, with out_valid delay measured from the accept edge:
  - 0x00000000 -> 0 after 2 cycles.
  - 0xF0F0000F -> 12 after 14 cycles.
  - 0xFFFFFFFF -> 32 after 34 cycles.
  - in_ready stays low throughout each operation.
- Backpressure: CTZ 0x100 with out_ready=0 for 5 cycles -> out_valid and out_result=8 held stable; in_ready=0; a second in_valid is not accepted until 1 cycle after the handshake.
- flush on the 3rd SCAN cycle of CPOP 0xFFFF -> IDLE next cycle, out_valid never rises; a following CTZ 0x2 returns 1.
- rst asserted mid-SCAN of CPOP 0xFFFFFFFF, asynchronously between edges -> outputs at reset values immediately; after release, CLZ 0x1 returns 31.
